// File: rtl/board_ram_arbiter_pkg.sv
// board_ram_arbiter_pkg: shared tetris board constants, requester indices and arbiter types
// Contents: NUM_REQ, REQ_* requester indices, BOARD_ADDR_W/BOARD_DATA_W defaults, owner FSM state, one-hot index helper
package board_ram_arbiter_pkg;
    localparam int NUM_REQ       = 3;
    localparam int REQ_COLLISION = 0;
    localparam int REQ_LINECLEAR = 1;
    localparam int REQ_LOCK      = 2;
    localparam int BOARD_ADDR_W  = 8;
    localparam int BOARD_DATA_W  = 6;

    typedef enum logic {IDLE, OWNED} own_state_t;

    // Index of a zero-or-one-hot requester vector; zero maps to 0
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] v);
        return v[0] ? 2'd0 : {v[2], v[1]};
    endfunction
endpackage

// File: rtl/board_ram_arbiter_if.sv
// board_ram_arbiter_if: requester bus and board RAM port of the arbiter
// Signals: req/addr0-2/wdata0-2/wren from requesters, gnt/rdata/rvalid/busy back to them,
//          ram_addr/ram_data/ram_wren to the RAM, ram_q from the RAM
// Modports: master (requesters + RAM side), slave (arbiter)
interface board_ram_arbiter_if #(
    parameter int ADDR_W = board_ram_arbiter_pkg::BOARD_ADDR_W,
    parameter int DATA_W = board_ram_arbiter_pkg::BOARD_DATA_W
) ();
    import board_ram_arbiter_pkg::*;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] wren;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] rvalid;
    logic [ADDR_W-1:0]  addr0;
    logic [ADDR_W-1:0]  addr1;
    logic [ADDR_W-1:0]  addr2;
    logic [DATA_W-1:0]  wdata0;
    logic [DATA_W-1:0]  wdata1;
    logic [DATA_W-1:0]  wdata2;
    logic [DATA_W-1:0]  rdata;
    logic               busy;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_data;
    logic               ram_wren;
    logic [DATA_W-1:0]  ram_q;

    modport master (
        output req, wren, addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_q,
        input  gnt, rvalid, rdata, busy, ram_addr, ram_data, ram_wren
    );

    modport slave (
        input  req, wren, addr0, addr1, addr2, wdata0, wdata1, wdata2, ram_q,
        output gnt, rvalid, rdata, busy, ram_addr, ram_data, ram_wren
    );
endinterface

// File: rtl/board_ram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick of the first requester after last_owner
// Ports: req (request vector), last_owner (index searched after), pick (one-hot winner, zero if no request)
module rr_pick
    import board_ram_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         last_owner,
    output logic [NUM_REQ-1:0] pick
);
    logic [2:0]         sh;
    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] first;

    // Rotate so last_owner+1 sits at bit 0, take the lowest set bit, rotate back
    always_comb begin
        sh    = {1'b0, last_owner} + 3'd1;
        rot   = NUM_REQ'({req, req} >> sh);
        first = rot & (~rot + 1'b1);
        pick  = NUM_REQ'(({first, first} << sh) >> NUM_REQ);
    end
endmodule

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: round-robin board RAM arbiter for collision, line-clear and lock requesters
// Ports: clk (rising edge), reset (async, active-high),
//        bus (slave side of board_ram_arbiter_if: req/addr/wdata/wren in, gnt/rdata/rvalid/busy out,
//             ram_addr/ram_data/ram_wren to the RAM, ram_q from the RAM with one-cycle latency)
module board_ram_arbiter
    import board_ram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 32,
    parameter int ADDR_W    = BOARD_ADDR_W,
    parameter int DATA_W    = BOARD_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    board_ram_arbiter_if.slave bus
);
    localparam int            CW      = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    own_state_t         state, state_n;
    logic [NUM_REQ-1:0] gnt, gnt_n, pick, issue, rd;
    logic [1:0]         last_owner, owner, rr_base;
    logic [CW-1:0]      count, count_n;
    logic               keep;
    logic [ADDR_W-1:0]  mux_addr;
    logic [DATA_W-1:0]  mux_data;

    assign owner = onehot_to_idx(gnt);
    // While owned, search after the owner so a revoked owner goes to the back of the line
    assign rr_base = (state == OWNED) ? owner : last_owner;

    rr_pick u_rr (
        .req        (bus.req),
        .last_owner (rr_base),
        .pick       (pick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= '0;
            last_owner <= 2'(REQ_LOCK);
            count      <= '0;
            rd         <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            count <= count_n;
            rd    <= issue & ~bus.wren;
            if (|gnt_n)
                last_owner <= onehot_to_idx(gnt_n);
        end
    end

    // Owner keeps the grant unless it drops req or hits the burst limit with someone waiting
    always_comb begin
        keep    = (state == OWNED) && bus.req[owner] && !(count >= MAX_CNT && |(bus.req & ~gnt));
        gnt_n   = keep ? gnt : pick;
        state_n = |gnt_n ? OWNED : IDLE;
        count_n = keep ? ((count == MAX_CNT) ? count : count + 1'b1) : (|gnt_n ? CW'(1) : '0);
    end

    always_comb begin
        issue        = gnt & bus.req;
        mux_addr     = issue[0] ? bus.addr0 : issue[1] ? bus.addr1 : issue[2] ? bus.addr2 : '0;
        mux_data     = issue[0] ? bus.wdata0 : issue[1] ? bus.wdata1 : issue[2] ? bus.wdata2 : '0;
        bus.ram_addr = mux_addr;
        bus.ram_data = mux_data;
        bus.ram_wren = |(issue & bus.wren);
        bus.gnt      = gnt;
        bus.busy     = |gnt;
        bus.rvalid   = rd;
        bus.rdata    = bus.ram_q;
    end
endmodule
